// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: accepts fetch addresses from the PC, issues in-order
// reads to instruction memory, buffers returned words in a DEPTH-slot in-order
// queue and hands {addr, instruction} pairs to decode over valid/ready.
// A flush discards everything queued; reads still in flight at that point are
// counted and their responses dropped in the DRAIN state.
// Optional feature macro: ALIGN_CHECK_EN (misaligned fetches become fault
// entries with no memory read, reported on inst_fault).

// Response-protocol checker: memory must never return data with no read pending.
module inst_fetch_unit_chk (
    input logic clock,
    input logic reset,
    input logic mem_valid,
    input logic in_run,
    input logic issued_zero,
    input logic drop_zero
);
    // Flag a returning word that matches no outstanding read.
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(mem_valid && ((in_run && issued_zero) || (!in_run && drop_zero))))
                else $error("inst_fetch_unit: mem_valid with no outstanding read");
        end
    end
endmodule

module inst_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
`ifdef ALIGN_CHECK_EN
    output logic              inst_fault,
`endif
    input  logic              inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     alloc_q, alloc_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     issued_q, issued_d;   // reads issued, data not yet returned
    logic [CW-1:0]     drop_q, drop_d;       // responses still to discard after flush
    logic [DEPTH-1:0]  full_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
`ifdef ALIGN_CHECK_EN
    logic [DEPTH-1:0]  fault_q;
`endif

    logic          misalign_s;
    logic          accept_s;
    logic          issue_s;
    logic          pop_s;
    logic          ret_s;        // response for a live slot
    logic          drain_ret_s;  // response to be discarded
    logic          fill_s;
    logic          fill_hit_s;
    logic [PW-1:0] fill_idx_s;
    logic [PW-1:0] scan_idx_s;
    logic          flush_run_s;

`ifdef ALIGN_CHECK_EN
    assign misalign_s = (req_addr[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    assign flush_run_s = (state_q == ST_RUN) && flush;
    assign req_ready   = !reset && (state_q == ST_RUN) && !flush && (count_q < CW'(DEPTH));
    assign accept_s    = req_valid && req_ready;
    assign issue_s     = accept_s && !misalign_s;
    assign mem_rd      = issue_s;
    assign mem_addr    = {req_addr[ADDR_W-1:2], 2'b00};

    assign inst_valid  = !reset && (state_q == ST_RUN) && (count_q != '0) && full_q[rd_q];
    assign inst_addr   = addr_q[rd_q];
    assign inst_data   = data_q[rd_q];
`ifdef ALIGN_CHECK_EN
    assign inst_fault  = inst_valid && fault_q[rd_q];
`endif
    assign pop_s       = inst_valid && inst_ready;

    assign ret_s       = (state_q == ST_RUN) && mem_valid && (issued_q != '0);
    assign drain_ret_s = (state_q == ST_DRAIN) && mem_valid && (drop_q != '0);
    assign fill_s      = ret_s && fill_hit_s && !flush;

    // Locate the oldest allocated slot still waiting for memory data; fault
    // entries are born full, so they are skipped and ordering is preserved.
    always_comb begin
        fill_hit_s = 1'b0;
        fill_idx_s = rd_q;
        scan_idx_s = rd_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx_s = rd_q + PW'(i);
            if (!fill_hit_s && (CW'(i) < count_q) && !full_q[scan_idx_s]) begin
                fill_hit_s = 1'b1;
                fill_idx_s = scan_idx_s;
            end else begin
                fill_hit_s = fill_hit_s;
            end
        end
    end

    // Next-state logic for pointers, occupancy, outstanding reads and RUN/DRAIN.
    always_comb begin
        state_d  = state_q;
        alloc_d  = alloc_q;
        rd_d     = rd_q;
        count_d  = count_q;
        issued_d = issued_q;
        drop_d   = drop_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    alloc_d  = '0;
                    rd_d     = '0;
                    count_d  = '0;
                    issued_d = '0;
                    drop_d   = issued_q - {{PW{1'b0}}, ret_s};
                    state_d  = (drop_d != '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    alloc_d  = accept_s ? (alloc_q + 1'b1) : alloc_q;
                    rd_d     = pop_s ? (rd_q + 1'b1) : rd_q;
                    count_d  = count_q + {{PW{1'b0}}, accept_s} - {{PW{1'b0}}, pop_s};
                    issued_d = issued_q + {{PW{1'b0}}, issue_s} - {{PW{1'b0}}, ret_s};
                end
            end
            ST_DRAIN: begin
                if (drain_ret_s) begin
                    drop_d  = drop_q - 1'b1;
                    state_d = (drop_q == CW'(1)) ? ST_RUN : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_RUN;
            alloc_q  <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            issued_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            alloc_q  <= alloc_d;
            rd_q     <= rd_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            drop_q   <= drop_d;
        end
    end

    // Slot storage: address on accept, data on fill, full bit cleared on pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= '0;
`ifdef ALIGN_CHECK_EN
            fault_q <= '0;
`endif
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (flush_run_s) begin
            full_q <= '0;
`ifdef ALIGN_CHECK_EN
            fault_q <= '0;
`endif
        end else begin
            if (accept_s) begin
                addr_q[alloc_q] <= req_addr;
                full_q[alloc_q] <= misalign_s;
`ifdef ALIGN_CHECK_EN
                fault_q[alloc_q] <= misalign_s;
                if (misalign_s) begin
                    data_q[alloc_q] <= '0;
                end
`endif
            end
            if (fill_s) begin
                data_q[fill_idx_s] <= mem_data;
                full_q[fill_idx_s] <= 1'b1;
            end
            if (pop_s) begin
                full_q[rd_q] <= 1'b0;
            end
        end
    end

    inst_fetch_unit_chk u_chk (
        .clock       (clock),
        .reset       (reset),
        .mem_valid   (mem_valid),
        .in_run      (state_q == ST_RUN),
        .issued_zero (issued_q == '0),
        .drop_zero   (drop_q == '0)
    );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: reset, single fetch latency, queue full
// and drain order, flush with drain, flush corner cases, a 64-fetch stream and
// (with ALIGN_CHECK_EN) fault entries for misaligned fetches.
module tb_inst_fetch_unit;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        inst_valid;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_ready;
`ifdef ALIGN_CHECK_EN
    logic        inst_fault;
`endif

    int checks = 0;
    int errors = 0;

    inst_fetch_unit #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_valid  (mem_valid),
        .mem_data   (mem_data),
        .inst_valid (inst_valid),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
`ifdef ALIGN_CHECK_EN
        .inst_fault (inst_fault),
`endif
        .inst_ready (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    initial begin
        logic [31:0] a_v;
        reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_1234; flush = 1'b0;
        mem_valid = 1'b0; mem_data = 32'h0; inst_ready = 1'b0;
        tick;
        // reset cycle: everything held off even with a request presented
        settle;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_mem_rd", {63'd0, mem_rd}, 64'd0);
`ifdef ALIGN_CHECK_EN
        chk("rst_inst_fault", {63'd0, inst_fault}, 64'd0);
`endif
        tick;
        reset = 1'b0; req_valid = 1'b0;
        settle;
        chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
        chk("post_rst_ivalid", {63'd0, inst_valid}, 64'd0);
        tick;

        // ---- single fetch, memory returns two cycles after issue ----
        req_valid = 1'b1; req_addr = 32'h8000_0000;
        settle;
        chk("t1_mem_rd", {63'd0, mem_rd}, 64'd1);
        chk("t1_mem_addr", {32'd0, mem_addr}, {32'd0, 32'h8000_0000});
        tick;
        req_valid = 1'b0;
        settle;
        chk("t1_iv_wait", {63'd0, inst_valid}, 64'd0);
        tick;
        mem_valid = 1'b1; mem_data = 32'hD503_201F;
        settle;
        chk("t1_iv_ret", {63'd0, inst_valid}, 64'd0);
        tick;
        mem_valid = 1'b0; inst_ready = 1'b1;
        settle;
        chk("t1_iv", {63'd0, inst_valid}, 64'd1);
        chk("t1_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_0000});
        chk("t1_data", {32'd0, inst_data}, {32'd0, 32'hD503_201F});
        tick;
        inst_ready = 1'b0;
        settle;
        chk("t1_iv_after", {63'd0, inst_valid}, 64'd0);
        tick;

        // ---- fill the queue with decode stalled, then release ----
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'h8000_0000 + 32'(4 * i);
            mem_valid = (i > 0);
            mem_data  = word(32'h8000_0000 + 32'(4 * (i - 1)));
            settle;
            chk("t2_ready", {63'd0, req_ready}, 64'd1);
            chk("t2_mem_rd", {63'd0, mem_rd}, 64'd1);
            tick;
        end
        req_valid = 1'b1; req_addr = 32'h8000_0010;
        mem_valid = 1'b1; mem_data = word(32'h8000_000C);
        settle;
        chk("t2_full_ready", {63'd0, req_ready}, 64'd0);
        chk("t2_full_mem_rd", {63'd0, mem_rd}, 64'd0);
        chk("t2_full_iv", {63'd0, inst_valid}, 64'd1);
        tick;
        mem_valid = 1'b0; req_valid = 1'b0; inst_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            settle;
            a_v = 32'h8000_0000 + 32'(4 * j);
            chk("t2_pop_iv", {63'd0, inst_valid}, 64'd1);
            chk("t2_pop_addr", {32'd0, inst_addr}, {32'd0, a_v});
            chk("t2_pop_data", {32'd0, inst_data}, {32'd0, word(a_v)});
            if (j == 0) chk("t2_ready_pop0", {63'd0, req_ready}, 64'd0);
            if (j == 1) chk("t2_ready_pop1", {63'd0, req_ready}, 64'd1);
            tick;
        end
        inst_ready = 1'b0;
        settle;
        chk("t2_empty", {63'd0, inst_valid}, 64'd0);
        tick;

        // ---- three reads in flight, flush, drain three responses ----
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = 32'h8000_0100 + 32'(4 * i);
            tick;
        end
        req_valid = 1'b0; flush = 1'b1;
        settle;
        chk("t3_flush_ready", {63'd0, req_ready}, 64'd0);
        tick;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_data = 32'hDEAD_0000 + 32'(i);
            flush = (i == 1);
            settle;
            chk("t3_drain_ready", {63'd0, req_ready}, 64'd0);
            chk("t3_drain_iv", {63'd0, inst_valid}, 64'd0);
            tick;
        end
        mem_valid = 1'b0; flush = 1'b0;
        req_valid = 1'b1; req_addr = 32'h8000_1000;
        settle;
        chk("t3_run_ready", {63'd0, req_ready}, 64'd1);
        chk("t3_run_iv", {63'd0, inst_valid}, 64'd0);
        chk("t3_mem_rd", {63'd0, mem_rd}, 64'd1);
        tick;
        req_valid = 1'b0; mem_valid = 1'b1; mem_data = 32'h0000_0013;
        tick;
        mem_valid = 1'b0; inst_ready = 1'b1;
        settle;
        chk("t3_iv", {63'd0, inst_valid}, 64'd1);
        chk("t3_addr", {32'd0, inst_addr}, {32'd0, 32'h8000_1000});
        chk("t3_data", {32'd0, inst_data}, {32'd0, 32'h0000_0013});
        tick;
        inst_ready = 1'b0;

        // ---- flush with empty queue; flush alongside last response ----
        flush = 1'b1;
        settle;
        chk("t4_flush0_ready", {63'd0, req_ready}, 64'd0);
        tick;
        flush = 1'b0;
        settle;
        chk("t4_empty_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_addr = 32'h8000_0200;
        tick;
        req_valid = 1'b0; flush = 1'b1; mem_valid = 1'b1; mem_data = 32'h1111_2222;
        tick;
        flush = 1'b0; mem_valid = 1'b0;
        settle;
        chk("t4_same_ready", {63'd0, req_ready}, 64'd1);
        chk("t4_same_iv", {63'd0, inst_valid}, 64'd0);
        tick;

        // ---- 64-fetch stream, one-cycle memory, decode always ready ----
        inst_ready = 1'b1;
        for (int k = 0; k < 66; k++) begin
            req_valid = (k < 64);
            req_addr  = 32'h8000_2000 + 32'(4 * k);
            mem_valid = (k >= 1) && (k <= 64);
            mem_data  = word(32'h8000_2000 + 32'(4 * (k - 1)));
            settle;
            if (k < 64) chk("t5_ready", {63'd0, req_ready}, 64'd1);
            if (k >= 2) begin
                a_v = 32'h8000_2000 + 32'(4 * (k - 2));
                chk("t5_iv", {63'd0, inst_valid}, 64'd1);
                chk("t5_addr", {32'd0, inst_addr}, {32'd0, a_v});
                chk("t5_data", {32'd0, inst_data}, {32'd0, word(a_v)});
            end
            tick;
        end
        req_valid = 1'b0; mem_valid = 1'b0;
        settle;
        chk("t5_end_iv", {63'd0, inst_valid}, 64'd0);
        chk("t5_end_ready", {63'd0, req_ready}, 64'd1);
        tick;
        inst_ready = 1'b0;

`ifdef ALIGN_CHECK_EN
        // ---- misaligned fetch between two aligned ones ----
        req_valid = 1'b1; req_addr = 32'h8000_3000;
        settle;
        chk("t6_rd0", {63'd0, mem_rd}, 64'd1);
        tick;
        req_addr = 32'h8000_3002; mem_valid = 1'b1; mem_data = word(32'h8000_3000);
        settle;
        chk("t6_rd1", {63'd0, mem_rd}, 64'd0);
        chk("t6_ready1", {63'd0, req_ready}, 64'd1);
        tick;
        req_addr = 32'h8000_3008; mem_valid = 1'b0;
        settle;
        chk("t6_rd2", {63'd0, mem_rd}, 64'd1);
        tick;
        req_valid = 1'b0; mem_valid = 1'b1; mem_data = word(32'h8000_3008);
        tick;
        mem_valid = 1'b0; inst_ready = 1'b1;
        settle;
        chk("t6_a0", {32'd0, inst_addr}, {32'd0, 32'h8000_3000});
        chk("t6_f0", {63'd0, inst_fault}, 64'd0);
        chk("t6_d0", {32'd0, inst_data}, {32'd0, word(32'h8000_3000)});
        tick;
        settle;
        chk("t6_iv1", {63'd0, inst_valid}, 64'd1);
        chk("t6_a1", {32'd0, inst_addr}, {32'd0, 32'h8000_3002});
        chk("t6_f1", {63'd0, inst_fault}, 64'd1);
        chk("t6_d1", {32'd0, inst_data}, 64'd0);
        tick;
        settle;
        chk("t6_a2", {32'd0, inst_addr}, {32'd0, 32'h8000_3008});
        chk("t6_f2", {63'd0, inst_fault}, 64'd0);
        chk("t6_d2", {32'd0, inst_data}, {32'd0, word(32'h8000_3008)});
        tick;
        inst_ready = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
